// File: rtl/iter_shift_unit.sv
// iter_shift_unit
// ---------------------------------------------------------------------------
// Multi-cycle shift/rotate unit. Each accepted operation runs through a small
// shifter that moves at most STEP bits per cycle, so a long shift takes
// ceil(shamt/STEP) cycles. Only one operation is in flight at a time.
//
// Handshake (both sides): a transfer happens on a rising edge where valid and
// ready are both high. A producer holds valid (and its data) until that edge.
// in_ready depends only on state and rst, never on in_valid. out_valid and
// result are held stable until the out_ready edge.
//
// Ports:
//   clk        clock, all state changes on rising edge
//   rst        synchronous reset, active-high
//   in_valid   operation request
//   in_ready   unit is idle and can accept an operation
//   a          operand (XLEN bits)
//   shamt      shift amount 0..XLEN-1 (SW bits)
//   op         000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, others invalid
//   out_valid  result is valid
//   out_ready  consumer accepts result
//   result     final value (XLEN bits), driven from the working register
// ---------------------------------------------------------------------------
module iter_shift_unit #(
  parameter int XLEN = 32,
  parameter int STEP = 4,
  parameter int SW   = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a,
  input  logic [SW-1:0]   shamt,
  input  logic [2:0]      op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  // STEP and XLEN as (SW+1)-bit values for comparisons and rotate complements.
  localparam logic [SW:0]   STEP_W = (SW+1)'(STEP);
  localparam logic [SW:0]   XLEN_W = (SW+1)'(XLEN);
  // STEP as an SW-bit step amount. When STEP == XLEN it wraps to 0, but then
  // remaining (< XLEN) is never >= STEP, so this value is never selected.
  localparam logic [SW-1:0] STEP_S = SW'(STEP % XLEN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state, state_d;
  logic [XLEN-1:0] work, work_d;
  logic [SW-1:0]   remaining, remaining_d;
  logic [2:0]      op_q, op_d;

  // Per-cycle step amount: k = min(STEP, remaining).
  logic [SW-1:0]   k;
  logic [XLEN-1:0] stepped;
  logic [XLEN-1:0] sra_fill;
  logic            op_is_valid;
  logic            accept;

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign result    = work;
  assign accept    = in_valid && in_ready;

  assign op_is_valid = (op <= OP_ROR);

  always_comb begin
    k = ({1'b0, remaining} >= STEP_W) ? STEP_S : remaining;
  end

  // One step of the selected operation by k bits. SRA refills from the
  // current top bit; since every earlier step preserved it, that is the
  // original sign.
  always_comb begin
    sra_fill = work[XLEN-1] ? ~({XLEN{1'b1}} >> k) : '0;
    stepped  = work;
    case (op_q)
      OP_SLL:  stepped = work << k;
      OP_SRL:  stepped = work >> k;
      OP_SRA:  stepped = (work >> k) | sra_fill;
      // k >= 1 whenever SHIFT is active, so XLEN-k stays below XLEN.
      OP_ROL:  stepped = (work << k) | (work >> (XLEN_W - {1'b0, k}));
      OP_ROR:  stepped = (work >> k) | (work << (XLEN_W - {1'b0, k}));
      default: stepped = '0;
    endcase
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d     = state;
    work_d      = work;
    remaining_d = remaining;
    op_d        = op_q;
    case (state)
      IDLE: begin
        if (accept) begin
          op_d        = op;
          remaining_d = shamt;
          if (!op_is_valid) begin
            work_d  = '0;
            state_d = DONE;
          end else if (shamt == '0) begin
            work_d  = a;
            state_d = DONE;
          end else begin
            work_d  = a;
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        work_d      = stepped;
        remaining_d = remaining - k;
        if (remaining == k) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      work      <= '0;
      remaining <= '0;
      op_q      <= '0;
    end else begin
      state     <= state_d;
      work      <= work_d;
      remaining <= remaining_d;
      op_q      <= op_d;
    end
  end

endmodule

// File: tb/tb_iter_shift_unit.sv
// Bench for iter_shift_unit: three instances (STEP = 4, 1, 32) share the same
// stimulus; each is compared against a whole-operation arithmetic model.
module tb_iter_shift_unit;

  localparam int NI = 3;
  localparam int STEPS [NI] = '{4, 1, 32};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] a = '0;
  logic [4:0]  shamt = '0;
  logic [2:0]  op = '0;

  logic        in_ready_v  [NI];
  logic        out_valid_v [NI];
  logic [31:0] result_v    [NI];

  iter_shift_unit #(.XLEN(32), .STEP(4)) dut_s4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[0]),
    .a(a), .shamt(shamt), .op(op), .out_valid(out_valid_v[0]),
    .out_ready(out_ready), .result(result_v[0]));

  iter_shift_unit #(.XLEN(32), .STEP(1)) dut_s1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[1]),
    .a(a), .shamt(shamt), .op(op), .out_valid(out_valid_v[1]),
    .out_ready(out_ready), .result(result_v[1]));

  iter_shift_unit #(.XLEN(32), .STEP(32)) dut_s32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[2]),
    .a(a), .shamt(shamt), .op(op), .out_valid(out_valid_v[2]),
    .out_ready(out_ready), .result(result_v[2]));

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input int inst,
                       input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s step=%0d observed=%h expected=%h", tag, STEPS[inst], obs, expv);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] model(input logic [31:0] av,
                                        input logic [4:0] s,
                                        input logic [2:0] o);
    logic [63:0] t;
    case (o)
      3'd0: return av << s;
      3'd1: return av >> s;
      3'd2: return 32'($signed(av) >>> s);
      3'd3: begin t = {av, av} << s; return t[63:32]; end
      3'd4: begin t = {av, av} >> s; return t[31:0]; end
      default: return 32'h0;
    endcase
  endfunction

  function automatic int n_of(input logic [4:0] s, input logic [2:0] o, input int step);
    if (o > 3'd4) return 0;
    return (int'(s) + step - 1) / step;
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a negedge with all instances idle. Issues one operation with
  // out_ready high and checks per-cycle out_valid/in_ready/result timing.
  task automatic do_op(input logic [31:0] av, input logic [4:0] s, input logic [2:0] o);
    int n [NI];
    int maxn;
    logic [31:0] expv;
    expv = model(av, s, o);
    exp_q.push_back(expv);
    maxn = 0;
    for (int i = 0; i < NI; i++) begin
      n[i] = n_of(s, o, STEPS[i]);
      if (n[i] > maxn) maxn = n[i];
      check("ready_before_accept", i, 32'(in_ready_v[i]), 32'd1);
    end
    a = av; shamt = s; op = o; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    // Inputs are not sampled after acceptance: scramble them.
    in_valid = 1'b0; a = $urandom; shamt = 5'($urandom); op = 3'($urandom);
    expv = exp_q.pop_front();
    for (int j = 0; j <= maxn + 1; j++) begin
      for (int i = 0; i < NI; i++) begin
        if (j <= n[i]) begin
          check("out_valid_timing", i, 32'(out_valid_v[i]), 32'(j == n[i]));
          if (j == n[i]) check("result", i, result_v[i], expv);
          else           check("ready_busy", i, 32'(in_ready_v[i]), 32'd0);
        end else if (j == n[i] + 1) begin
          check("ready_after_done", i, 32'(in_ready_v[i]), 32'd1);
          check("valid_after_done", i, 32'(out_valid_v[i]), 32'd0);
        end
      end
      @(negedge clk);
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [31:0] held [NI];
    int n_rst [NI];
    int waited;
    logic all_done;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check("reset_in_ready", i, 32'(in_ready_v[i]), 32'd0);
      check("reset_out_valid", i, 32'(out_valid_v[i]), 32'd0);
      check("reset_result", i, result_v[i], 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NI; i++) check("release_in_ready", i, 32'(in_ready_v[i]), 32'd1);

    // Directed operations, latency checked for all three STEP values.
    do_op(32'h0000_0001, 5'd31, 3'd0);
    do_op(32'h8000_0010, 5'd5,  3'd2);
    do_op(32'h8000_0010, 5'd5,  3'd1);
    do_op(32'h0000_00F1, 5'd8,  3'd4);
    do_op(32'h8000_0001, 5'd1,  3'd3);
    do_op(32'hDEAD_BEEF, 5'd0,  3'd1);
    do_op(32'hDEAD_BEEF, 5'd9,  3'd7);
    do_op(32'h8765_4321, 5'd31, 3'd2);
    do_op(32'h8765_4321, 5'd31, 3'd4);

    // Backpressure: stall in DONE while offering new operations.
    a = 32'hCAFE_F00D; shamt = 5'd13; op = 3'd3; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    waited = 0;
    all_done = 1'b0;
    while (!all_done && waited < 64) begin
      all_done = out_valid_v[0] && out_valid_v[1] && out_valid_v[2];
      if (!all_done) begin
        @(negedge clk);
        waited++;
      end
    end
    for (int i = 0; i < NI; i++) begin
      check("bp_reached_done", i, 32'(out_valid_v[i]), 32'd1);
      held[i] = result_v[i];
      check("bp_result", i, result_v[i], model(32'hCAFE_F00D, 5'd13, 3'd3));
    end
    for (int c = 0; c < 5; c++) begin
      in_valid = ~in_valid; a = $urandom; shamt = 5'($urandom_range(1, 31));
      op = 3'($urandom_range(0, 4));
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        check("bp_valid_held", i, 32'(out_valid_v[i]), 32'd1);
        check("bp_result_held", i, result_v[i], held[i]);
        check("bp_in_ready_low", i, 32'(in_ready_v[i]), 32'd0);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check("bp_release_valid", i, 32'(out_valid_v[i]), 32'd0);
      check("bp_release_ready", i, 32'(in_ready_v[i]), 32'd1);
    end

    // Reset during the second step cycle of SLL by 20.
    for (int i = 0; i < NI; i++) n_rst[i] = n_of(5'd20, 3'd0, STEPS[i]);
    a = 32'hFFFF_FFFF; shamt = 5'd20; op = 3'd0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int j = 0; j < 2; j++) begin
      for (int i = 0; i < NI; i++)
        if (n_rst[i] > 2) check("rst_no_valid", i, 32'(out_valid_v[i]), 32'd0);
      if (j == 1) rst = 1'b1;
      @(negedge clk);
    end
    for (int i = 0; i < NI; i++) begin
      check("rst_mid_out_valid", i, 32'(out_valid_v[i]), 32'd0);
      check("rst_mid_result", i, result_v[i], 32'd0);
      check("rst_mid_in_ready", i, 32'(in_ready_v[i]), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check("rst_after_in_ready", i, 32'(in_ready_v[i]), 32'd1);
      check("rst_after_out_valid", i, 32'(out_valid_v[i]), 32'd0);
      check("rst_after_result", i, result_v[i], 32'd0);
    end
    do_op(32'h1234_5678, 5'd4, 3'd4);
    for (int i = 0; i < NI; i++)
      check("ror_constant", i, model(32'h1234_5678, 5'd4, 3'd4), 32'h8123_4567);

    // Random operations, including invalid opcodes and zero shifts.
    for (int t = 0; t < 40; t++)
      do_op($urandom, 5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL timeout bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
